// File: rtl/led_bank_if.sv
// Instruction bus shared by the peripherals: a 12-bit instruction word plus its valid strobe.
// The master drives the bus and the peripheral consumes it through the slave modport.
interface led_bank_if;
  logic [11:0] inst;
  logic        inst_en;

  modport master (output inst, output inst_en);
  modport slave  (input  inst, input  inst_en);
endinterface

// File: rtl/led_bank.sv
// Instruction-driven 8-bit LED bank with a per-bit hardware blink timed by an internal prescaler.
// Optional build macro LEDBANK_ERROR_OUT_EN adds an 'error' output that is high while in Error.
module led_bank #(
  parameter int BlinkWait = 25000000,
  parameter int BlinkSize = 25
) (
  input  logic        clock,
  input  logic        reset,
  led_bank_if.slave   bus,
  output logic [7:0]  leds
`ifdef LEDBANK_ERROR_OUT_EN
  ,
  output logic        error
`endif
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_READY = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLdv = 4'h1;
  localparam logic [3:0] OpLdb = 4'h2;
  localparam logic [3:0] OpTgl = 4'h3;
  localparam logic [3:0] OpClr = 4'h4;

  localparam logic [BlinkSize-1:0] WrapCount = BlinkSize'(BlinkWait - 1);

  state_e               state_q, state_d;
  logic [7:0]           value_q, value_d;
  logic [7:0]           mask_q, mask_d;
  logic [BlinkSize-1:0] prescaler_q, prescaler_d;
  logic                 phase_q, phase_d;

  logic [3:0] opcode;
  logic [7:0] imm;

  assign opcode = bus.inst[11:8];
  assign imm    = bus.inst[7:0];

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    mask_d      = mask_q;
    prescaler_d = prescaler_q;
    phase_d     = phase_q;

    case (state_q)
      ST_RESET: begin
        state_d     = ST_READY;
        value_d     = 8'h00;
        mask_d      = 8'h00;
        prescaler_d = '0;
        phase_d     = 1'b0;
      end

      ST_READY: begin
        // The prescaler step is computed first so an instruction issued on the
        // wrap cycle still sees the new phase, and CLR below can override it.
        if (prescaler_q == WrapCount) begin
          prescaler_d = '0;
          phase_d     = ~phase_q;
        end else begin
          prescaler_d = prescaler_q + BlinkSize'(1);
        end

        if (bus.inst_en) begin
          case (opcode)
            OpNop: ;
            OpLdv: value_d = imm;
            OpLdb: mask_d  = imm;
            OpTgl: value_d = value_q ^ imm;
            OpClr: begin
              value_d     = 8'h00;
              mask_d      = 8'h00;
              prescaler_d = '0;
              phase_d     = 1'b0;
            end
            default: begin
              state_d     = ST_ERROR;
              value_d     = 8'h00;
              mask_d      = 8'h00;
              prescaler_d = '0;
              phase_d     = 1'b0;
            end
          endcase
        end
      end

      // Error is sticky, and the unused encoding collapses into it.
      default: begin
        state_d     = ST_ERROR;
        value_d     = 8'h00;
        mask_d      = 8'h00;
        prescaler_d = '0;
        phase_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RESET;
      value_q     <= 8'h00;
      mask_q      <= 8'h00;
      prescaler_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      mask_q      <= mask_d;
      prescaler_q <= prescaler_d;
      phase_q     <= phase_d;
    end
  end

  assign leds = value_q & ~(mask_q & {8{phase_q}});

`ifdef LEDBANK_ERROR_OUT_EN
  assign error = (state_q != ST_RESET) && (state_q != ST_READY);
`endif

endmodule
